// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared state and SR input encodings for the SR flip-flop checker
package sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count up on inc, stick at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sr_ff_checker.sv
// rtl/sr_ff_checker.sv - reference-model response checker for an SR flip-flop
module sr_ff_checker
  import sr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] first_err_cyc
);

  state_t           state;
  state_t           state_nxt;
  logic             run_edge;
  logic             clear_run;
  logic             primed;
  logic             exp_known;
  logic             exp_q;
  logic [CNT_W-1:0] cycle_cnt;
  logic [1:0]       sr;
  logic             err_hit;
  logic             check_hit;
  logic             illegal_hit;

  assign sr = {s, r};

  // q/qbar only reflect a sampled {s,r} once at least one RUN edge has sampled;
  // the value check uses the model state left by the previous edge.
  assign check_hit   = run_edge && primed && exp_known;
  assign err_hit     = run_edge && primed && ((qbar == q) || (exp_known && (q != exp_q)));
  assign illegal_hit = run_edge && (sr == SR_ILL);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; stop takes priority over start in RUN.
  always_comb begin
    state_nxt = state;
    clear_run = 1'b0;
    run_edge  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          clear_run = 1'b1;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        run_edge = 1'b1;
        if (stop) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (err_cnt == '0);
        if (start) begin
          state_nxt = ST_RUN;
          clear_run = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reference model of the flip-flop, error pulse and first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed        <= 1'b0;
      exp_known     <= 1'b0;
      exp_q         <= 1'b0;
      err_pulse     <= 1'b0;
      first_err_cyc <= '0;
    end else begin
      err_pulse <= err_hit;
      if (clear_run) begin
        primed        <= 1'b0;
        exp_known     <= 1'b0;
        first_err_cyc <= '0;
      end else if (run_edge) begin
        primed <= 1'b1;
        case (sr)
          SR_HOLD: exp_q <= exp_q;
          SR_RST: begin
            exp_q     <= 1'b0;
            exp_known <= 1'b1;
          end
          SR_SET: begin
            exp_q     <= 1'b1;
            exp_known <= 1'b1;
          end
          default: exp_known <= 1'b0;
        endcase
        // err_cnt saturates and never returns to zero, so zero marks the first error.
        if (err_hit && (err_cnt == '0)) begin
          first_err_cyc <= cycle_cnt;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_run),
    .inc   (run_edge),
    .count (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_run),
    .inc   (err_hit),
    .count (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_illegal_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_run),
    .inc   (illegal_hit),
    .count (illegal_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_check_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_run),
    .inc   (check_hit),
    .count (check_cnt)
  );

endmodule

// File: tb/tb_sr_ff_checker.sv
// tb/tb_sr_ff_checker.sv - directed self-checking bench for sr_ff_checker
module tb_sr_ff_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sat_start = 1'b0;
  logic       sat_stop = 1'b0;
  logic       s = 1'b0;
  logic       r = 1'b0;
  logic       q;
  logic       qbar;
  logic       ff_q;
  logic       force_q = 1'b0;
  logic       tie_qbar = 1'b0;

  logic       busy, done, pass, err_pulse;
  logic [7:0] err_cnt, illegal_cnt, check_cnt, first_err_cyc;
  logic       s_busy, s_done, s_pass, s_err_pulse;
  logic [2:0] s_err_cnt, s_illegal_cnt, s_check_cnt, s_first_err_cyc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural SR flip-flop standing in for the observed DUT; 11 holds.
  always @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else if ({s, r} == 2'b01) ff_q <= 1'b0;
    else if ({s, r} == 2'b10) ff_q <= 1'b1;
  end

  assign q    = force_q ? 1'b0 : ff_q;
  assign qbar = tie_qbar ? q : ~ff_q;

  sr_ff_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s(s), .r(r), .q(q), .qbar(qbar),
    .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .illegal_cnt(illegal_cnt), .check_cnt(check_cnt), .first_err_cyc(first_err_cyc)
  );

  sr_ff_checker #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(sat_start), .stop(sat_stop), .s(s), .r(r), .q(q), .qbar(qbar),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
    .illegal_cnt(s_illegal_cnt), .check_cnt(s_check_cnt), .first_err_cyc(s_first_err_cyc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one clock of stimulus from a falling edge, return on the next falling edge.
  task automatic cyc(input logic s_i, input logic r_i, input logic st, input logic sp);
    s     = s_i;
    r     = r_i;
    start = st;
    stop  = sp;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    stop      = 1'b0;
    sat_start = 1'b0;
    sat_stop  = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err_cyc, 0);

    // Reset in the middle of a run
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    chk("mid_busy", busy, 1);
    chk("mid_illegal", illegal_cnt, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", err_cnt, 0);
    chk("abort_illegal", illegal_cnt, 0);
    chk("abort_check", check_cnt, 0);

    // Golden sweep 00,01,10,11,00
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("gold_done", done, 1);
    chk("gold_busy", busy, 0);
    chk("gold_pass", pass, 1);
    chk("gold_err", err_cnt, 0);
    chk("gold_illegal", illegal_cnt, 1);
    chk("gold_check", check_cnt, 2);

    // Stuck-at-0 on q while 10 then 00 is applied
    cyc(0, 0, 1, 0);
    force_q = 1'b1;
    cyc(1, 0, 0, 0);
    chk("stuck_pulse0", err_pulse, 0);
    chk("stuck_err0", err_cnt, 0);
    cyc(0, 0, 0, 0);
    chk("stuck_pulse1", err_pulse, 1);
    chk("stuck_err1", err_cnt, 1);
    chk("stuck_first1", first_err_cyc, 1);
    cyc(0, 0, 0, 1);
    chk("stuck_pulse2", err_pulse, 1);
    chk("stuck_err2", err_cnt, 2);
    chk("stuck_done", done, 1);
    chk("stuck_pass", pass, 0);
    chk("stuck_check", check_cnt, 2);
    cyc(0, 0, 0, 0);
    chk("stuck_pulse_end", err_pulse, 0);
    chk("stuck_err_hold", err_cnt, 2);
    chk("stuck_first_hold", first_err_cyc, 1);
    force_q = 1'b0;

    // Complement fault over four cycles of 00
    tie_qbar = 1'b1;
    cyc(0, 0, 1, 0);
    chk("comp_cleared", err_cnt, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("comp_err", err_cnt, 4);
    chk("comp_check", check_cnt, 0);
    chk("comp_pass", pass, 0);
    chk("comp_first", first_err_cyc, 1);
    tie_qbar = 1'b0;

    // start+stop together in RUN, then a fresh run clears everything
    force_q = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ctl_err1", err_cnt, 1);
    chk("ctl_first", first_err_cyc, 1);
    cyc(0, 0, 1, 1);
    chk("ctl_done", done, 1);
    chk("ctl_busy", busy, 0);
    chk("ctl_err2", err_cnt, 2);
    force_q = 1'b0;
    cyc(0, 0, 1, 0);
    chk("rerun_busy", busy, 1);
    chk("rerun_err", err_cnt, 0);
    chk("rerun_illegal", illegal_cnt, 0);
    chk("rerun_check", check_cnt, 0);
    chk("rerun_first", first_err_cyc, 0);
    cyc(0, 0, 1, 0);
    chk("start_in_run_busy", busy, 1);
    chk("start_in_run_done", done, 0);
    cyc(0, 0, 0, 1);
    chk("rerun_pass", pass, 1);

    // Saturation with a 3-bit checker and twelve cycles of 11
    sat_start = 1'b1;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    chk("sat_ill3", s_illegal_cnt, 3);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    chk("sat_ill7", s_illegal_cnt, 7);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    chk("sat_ill_hold", s_illegal_cnt, 7);
    chk("sat_err", s_err_cnt, 0);
    sat_stop = 1'b1;
    cyc(0, 0, 0, 0);
    chk("sat_done", s_done, 1);
    chk("sat_ill_final", s_illegal_cnt, 7);
    chk("main_untouched", illegal_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_ff_checker.md
Name: sr_ff_checker

Overview:
- Synthesizable response checker that sits on the output side of an SR flip-flop DUT (sr_ff) and observes s, r, q and qbar every clock.
- Runs its own reference model of the flip-flop, compares the DUT outputs cycle by cycle, and counts forbidden input combinations.
- Reports mismatches, a pass/fail verdict and the cycle index of the first failure.
- Complements the stimulus driver: the driver writes {s,r}, this block reads the response and judges it.

Parameters:
- CNT_W, 8, width of all counters (cycle, error, illegal, check); every counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock; shared with the DUT, all sampling on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle pulse; begins a checking run
- stop  input  1  single-cycle pulse; ends a checking run
- s  input  1  DUT set input, as applied to the DUT
- r  input  1  DUT reset input, as applied to the DUT
- q  input  1  DUT output q
- qbar  input  1  DUT output qbar
- busy  output  1  high while in RUN
- done  output  1  high while in DONE
- pass  output  1  valid in DONE; 1 when err_cnt==0
- err_pulse  output  1  one-cycle pulse on the cycle an error is detected
- err_cnt  output  CNT_W  error cycles detected
- illegal_cnt  output  CNT_W  cycles sampled with s=r=1
- check_cnt  output  CNT_W  cycles where a q comparison was performed
- first_err_cyc  output  CNT_W  cycle_cnt value at the first error; 0 if none

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, all outputs 0, exp_known=0, exp_q=0, cycle_cnt=0. Reset mid-run aborts the run and discards all results.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start go to RUN; clear counters, exp_known and first_err_cyc.
  - RUN: on stop go to DONE. If stop and start arrive together, stop wins.
  - DONE: hold all results. On start, re-enter RUN with counters cleared.
  - start while in RUN is ignored.
- Timing model: the DUT registers {s,r} on edge k. The checker samples the same s,r on edge k and compares q/qbar on edge k+1.
- Reference model, updated every RUN edge from the sampled s,r:
  - 00: exp_q holds.
  - 01: exp_q=0, exp_known=1.
  - 10: exp_q=1, exp_known=1.
  - 11: exp_known=0 and illegal_cnt increments.
- exp_known=0 after entering RUN. Until a 01 or 10 is sampled, the state is unknown, so 00 keeps it unknown.
- Checks on each RUN edge, using the model state from the previous edge:
  - Complement check, every cycle: error if qbar != ~q.
  - Value check, only if exp_known was 1: error if q != exp_q. check_cnt increments when this check is performed.
- Any error in a cycle: err_cnt increments by 1, and only by 1 even if both checks fail. err_pulse=1 on the next cycle (registered).
- first_err_cyc latches cycle_cnt on the first error of the run only.
- cycle_cnt increments on every RUN edge, starting at 0 on the first RUN edge.
- The edge that performs the IDLE->RUN transition does no sampling. The first compare happens on the edge after the first sample.
- Counters saturate at their maximum value and never wrap.
- pass = (state==DONE) && (err_cnt==0). In all other states pass=0.
- The 11 input is counted, not treated as an error. q is not checked until a 01 or 10 re-establishes the state.

Decomposition:
- Shared package sr_pkg holds:
  - the state enum (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - SR input encodings (SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_ILL=2'b11).
- One natural sub-module, sat_counter (CNT_W wide, with clear and inc inputs), instantiated four times.

Test Plan:
- Reset: drive rst=1 for 2 cycles mid-RUN -> next cycle state=IDLE; busy, done, pass, err_cnt, illegal_cnt and check_cnt all 0.
- Golden sweep: connect to a correct sr_ff. Apply start, then {s,r}=0,1,2,3,0, each held for 1 clock, then stop -> done=1, pass=1, err_cnt=0, illegal_cnt=1, check_cnt=2 (compares after 01 and 10; the 11 and the following 00 are unknown).
- Stuck-at fault: force q=0 while the stimulus is 10 then 00 after start -> err_cnt=2, err_pulse asserted twice, first_err_cyc=1, and after stop pass=0.
- Complement fault: tie qbar=q during a 4-cycle run of 00 -> err_cnt=4 even with exp_known=0, check_cnt=0.
- Saturation: CNT_W=3, 12 cycles of 11 -> illegal_cnt=7, and it stays at 7.
- Control corner: assert start and stop together in RUN -> DONE. Then start -> RUN with all counters 0 and first_err_cyc=0.
